// File: rtl/bin2bcd4_seq.sv
// Iterative 14-bit binary to 4-digit BCD converter (double dabble, one bit per clock).
// Latency: done 14 edges after start accept; start is ignored while busy, and digits/ovf hold between completions.
module bin2bcd4_seq #(
    parameter bit CLAMP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic [3:0]  num4,
    output logic [3:0]  num3,
    output logic [3:0]  num2,
    output logic [3:0]  num1
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t      state_q, state_d;
    logic [13:0] bin_q, bin_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  tenk_q, tenk_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;
    logic [15:0] num_q, num_d;
    logic [19:0] adj;
    logic [33:0] shifted;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        tenk_d  = tenk_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        num_d   = num_q;

        // The ten-thousands nibble is corrected too, so the low four digits stay exact above 9999.
        adj     = {add3(tenk_q), add3(bcd_q[15:12]), add3(bcd_q[11:8]),
                   add3(bcd_q[7:4]), add3(bcd_q[3:0])};
        shifted = {adj, bin_q} << 1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin;
                    bcd_d   = 16'd0;
                    tenk_d  = 4'd0;
                    cnt_d   = 4'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {tenk_d, bcd_d, bin_d} = shifted;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    ovf_d   = (shifted[33:30] != 4'd0);
                    num_d   = (CLAMP && ovf_d) ? 16'h9999 : shifted[29:14];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= 14'd0;
            bcd_q   <= 16'd0;
            tenk_q  <= 4'd0;
            cnt_q   <= 4'd0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            num_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            tenk_q  <= tenk_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            num_q   <= num_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign ovf  = ovf_q;
    assign num4 = num_q[15:12];
    assign num3 = num_q[11:8];
    assign num2 = num_q[7:4];
    assign num1 = num_q[3:0];

endmodule

// File: tb/tb_bin2bcd4_seq.sv
// Bench for bin2bcd4_seq: runs a clamping and a wrapping instance side by side against a decimal arithmetic model.
module tb_bin2bcd4_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] bin;

    logic        busy1, done1, ovf1, busy0, done0, ovf0;
    logic [3:0]  a4, a3, a2, a1, b4, b3, b2, b1;
    logic [15:0] dig1, dig0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bin2bcd4_seq #(.CLAMP(1'b1)) u_c1 (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy1), .done(done1), .ovf(ovf1),
        .num4(a4), .num3(a3), .num2(a2), .num1(a1)
    );

    bin2bcd4_seq #(.CLAMP(1'b0)) u_c0 (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy0), .done(done0), .ovf(ovf0),
        .num4(b4), .num3(b3), .num2(b2), .num1(b1)
    );

    assign dig1 = {a4, a3, a2, a1};
    assign dig0 = {b4, b3, b2, b1};

    function automatic logic [15:0] ref_dig(input int v, input bit clamp);
        int d;
        d = (clamp && v > 9999) ? 9999 : v % 10000;
        return {4'(d / 1000), 4'((d / 100) % 10), 4'((d / 10) % 10), 4'(d % 10)};
    endfunction

    // Starts a conversion and returns at the done cycle (or after a bounded wait).
    task automatic run_conv(input logic [13:0] v, input bit hold, output int lat,
                            output bit stable, output bit busy_ok);
        logic [15:0] p1, p0;
        logic        po1, po0;
        p1 = dig1; p0 = dig0; po1 = ovf1; po0 = ovf0;
        bin = v;
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        bin = 14'($urandom);
        lat = 0; stable = 1'b1; busy_ok = 1'b1;
        while (!done1 && lat < 40) begin
            if (!busy1 || !busy0) busy_ok = 1'b0;
            if (dig1 !== p1 || dig0 !== p0 || ovf1 !== po1 || ovf0 !== po0) stable = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; bin = 14'd0;
        #12;
        total++;
        if ({busy1, done1, ovf1, dig1, busy0, done0, ovf0, dig0} !== 38'd0) begin
            bad++;
            $display("FAIL reset_state: got %h/%h required all zero",
                     {busy1, done1, ovf1, dig1}, {busy0, done0, ovf0, dig0});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int lat; bit stable, bok;
        run_conv(14'd1234, 1'b0, lat, stable, bok);
        total++;
        if (lat !== 14) begin bad++; $display("FAIL basic_latency: got %0d required 14", lat); end
        total++;
        if (!stable || !bok) begin
            bad++; $display("FAIL basic_hold: stable=%0d busy_ok=%0d required 1 1", stable, bok);
        end
        total++;
        if (dig1 !== 16'h1234 || ovf1 !== 1'b0 || busy1 !== 1'b0) begin
            bad++; $display("FAIL basic_result: got %h ovf=%b busy=%b required 1234 0 0", dig1, ovf1, busy1);
        end
        @(posedge clk); #1;
        total++;
        if (done1 !== 1'b0 || dig1 !== 16'h1234) begin
            bad++; $display("FAIL done_width: done=%b dig=%h required 0 1234", done1, dig1);
        end
    endtask

    task automatic test_corners;
        int vals[5] = '{0, 9999, 10000, 16383, 12345};
        int lat; bit stable, bok;
        foreach (vals[i]) begin
            run_conv(14'(vals[i]), 1'b0, lat, stable, bok);
            total++;
            if (dig1 !== ref_dig(vals[i], 1'b1) || dig0 !== ref_dig(vals[i], 1'b0) ||
                ovf1 !== (vals[i] > 9999) || ovf0 !== (vals[i] > 9999) || lat !== 14) begin
                bad++;
                $display("FAIL corner_%0d: got %h/%h ovf=%b%b lat=%0d required %h/%h ovf=%b lat=14",
                         vals[i], dig1, dig0, ovf1, ovf0, lat,
                         ref_dig(vals[i], 1'b1), ref_dig(vals[i], 1'b0), vals[i] > 9999);
            end
        end
    endtask

    task automatic test_ignored_start;
        int lat;
        bin = 14'd42; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bin = 14'd7777; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 6;
        while (!done1 && lat < 40) begin @(posedge clk); #1; lat++; end
        total++;
        if (dig1 !== 16'h0042 || lat !== 14) begin
            bad++; $display("FAIL ignored_start: got %h lat=%0d required 0042 lat=14", dig1, lat);
        end
        repeat (16) @(posedge clk);
        #1;
        total++;
        if (busy1 !== 1'b0 || dig1 !== 16'h0042) begin
            bad++; $display("FAIL no_queue: busy=%b dig=%h required 0 0042", busy1, dig1);
        end
    endtask

    task automatic test_back_to_back;
        int lat; bit stable, bok;
        time t1, t2;
        run_conv(14'd5678, 1'b1, lat, stable, bok);
        t1 = $time;
        total++;
        if (dig1 !== 16'h5678 || lat !== 14) begin
            bad++; $display("FAIL b2b_first: got %h lat=%0d required 5678 lat=14", dig1, lat);
        end
        run_conv(14'd901, 1'b0, lat, stable, bok);
        t2 = $time;
        total++;
        if (dig1 !== 16'h0901 || dig0 !== 16'h0901 || (t2 - t1) !== 150) begin
            bad++; $display("FAIL b2b_second: got %h spacing=%0t required 0901 spacing=150", dig1, t2 - t1);
        end
    endtask

    task automatic test_reset_mid;
        bit seen_done;
        bin = 14'd4321; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        total++;
        if ({busy1, done1, ovf1, dig1, busy0, done0, ovf0, dig0} !== 38'd0) begin
            bad++; $display("FAIL async_reset: got %h/%h required all zero",
                            {busy1, done1, ovf1, dig1}, {busy0, done0, ovf0, dig0});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done1 || done0 || busy1 || busy0) seen_done = 1'b1;
        end
        total++;
        if (seen_done !== 1'b0) begin
            bad++; $display("FAIL abort_no_done: activity=%b required 0", seen_done);
        end
    endtask

    task automatic test_random;
        int v, lat; bit stable, bok;
        for (int i = 0; i < 40; i++) begin
            v = (i % 3 == 0) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 16383));
            run_conv(14'(v), 1'b0, lat, stable, bok);
            total++;
            if (dig1 !== ref_dig(v, 1'b1) || ovf1 !== (v > 9999) || lat !== 14 || !stable || !bok) begin
                bad++; $display("FAIL rand_clamp v=%0d: got %h ovf=%b lat=%0d required %h ovf=%b",
                                v, dig1, ovf1, lat, ref_dig(v, 1'b1), v > 9999);
            end
            total++;
            if (dig0 !== ref_dig(v, 1'b0) || ovf0 !== (v > 9999)) begin
                bad++; $display("FAIL rand_wrap v=%0d: got %h ovf=%b required %h ovf=%b",
                                v, dig0, ovf0, ref_dig(v, 1'b0), v > 9999);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
